// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues MIPS R-type instructions from an internal register file to a combinational ALU and writes results back.
// Optional feature macro ALU_RESULT_CHECK_EN: reference model flags ALU result mismatches on chk_err.
module alu_issue_ctrl #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic [5:0]    alu_ctl,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  output logic          wb_valid,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          illegal,
  output logic          chk_err
);

  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_SLT  = 6'd42;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t        state_r;
  logic          ready_r;
  logic [5:0]    op_r;
  logic [5:0]    funct_r;
  logic [4:0]    rd_r;
  logic [DW-1:0] opa_r;
  logic [DW-1:0] opb_r;
  logic [DW-1:0] result_r;
  logic [5:0]    alu_ctl_r;
  logic [DW-1:0] alu_a_r;
  logic [DW-1:0] alu_b_r;
  logic          wb_valid_r;
  logic [4:0]    wb_rd_r;
  logic [DW-1:0] wb_data_r;
  logic          illegal_r;
  logic [DW-1:0] rf_r [NREG];

  logic          accept_s;
  logic          rf_we_s;
  logic [4:0]    rf_waddr_s;
  logic [DW-1:0] rf_wdata_s;
  logic          unused_s;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (fn)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return (op == 6'd0) && ok;
  endfunction

  // The ALU only implements the wrapping forms; unsigned variants alias them.
  function automatic logic [5:0] map_ctl(input logic [5:0] fn);
    logic [5:0] ctl;
    case (fn)
      F_ADDU:  ctl = F_ADD;
      F_SUBU:  ctl = F_SUB;
      default: ctl = fn;
    endcase
    return ctl;
  endfunction

  assign instr_ready = ready_r && !cfg_we;
  assign accept_s    = instr_valid && instr_ready;
  assign unused_s    = ^instr[10:6];

  assign alu_ctl  = alu_ctl_r;
  assign alu_a    = alu_a_r;
  assign alu_b    = alu_b_r;
  assign wb_valid = wb_valid_r;
  assign wb_rd    = wb_rd_r;
  assign wb_data  = wb_data_r;
  assign illegal  = illegal_r;

`ifdef ALU_RESULT_CHECK_EN
  logic chk_err_r;

  function automatic logic [DW-1:0] ref_result(input logic [5:0] ctl,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (ctl)
      F_ADD:   r = a + b;
      F_SUB:   r = a - b;
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_SLT:   r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = {DW{1'b0}};
    endcase
    return r;
  endfunction

  assign chk_err = chk_err_r;
`else
  assign chk_err = 1'b0;
`endif

  // Register-file write port: preload in IDLE, write-back in WB (entry 0 never written).
  always_comb begin
    rf_we_s    = 1'b0;
    rf_waddr_s = cfg_addr;
    rf_wdata_s = cfg_data;
    case (state_r)
      S_IDLE: begin
        if (cfg_we && (cfg_addr != 5'd0)) begin
          rf_we_s = 1'b1;
        end else begin
          rf_we_s = 1'b0;
        end
      end
      S_WB: begin
        rf_waddr_s = rd_r;
        rf_wdata_s = result_r;
        if (rd_r != 5'd0) begin
          rf_we_s = 1'b1;
        end else begin
          rf_we_s = 1'b0;
        end
      end
      default: rf_we_s = 1'b0;
    endcase
  end

  // Register file storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= {DW{1'b0}};
      end
    end else if (rf_we_s) begin
      rf_r[rf_waddr_s] <= rf_wdata_s;
    end
  end

  // Issue FSM with registered ALU drive, write-back and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      ready_r    <= 1'b0;
      op_r       <= 6'd0;
      funct_r    <= 6'd0;
      rd_r       <= 5'd0;
      opa_r      <= {DW{1'b0}};
      opb_r      <= {DW{1'b0}};
      result_r   <= {DW{1'b0}};
      alu_ctl_r  <= 6'd0;
      alu_a_r    <= {DW{1'b0}};
      alu_b_r    <= {DW{1'b0}};
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= {DW{1'b0}};
      illegal_r  <= 1'b0;
`ifdef ALU_RESULT_CHECK_EN
      chk_err_r  <= 1'b0;
`endif
    end else begin
      wb_valid_r <= 1'b0;
      illegal_r  <= 1'b0;
`ifdef ALU_RESULT_CHECK_EN
      chk_err_r  <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r    <= instr[31:26];
            rd_r    <= instr[15:11];
            funct_r <= instr[5:0];
            opa_r   <= rf_r[instr[25:21]];
            opb_r   <= rf_r[instr[20:16]];
            ready_r <= 1'b0;
            state_r <= S_DECODE;
          end else begin
            ready_r <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_DECODE: begin
          if (is_legal(op_r, funct_r)) begin
            alu_ctl_r <= map_ctl(funct_r);
            alu_a_r   <= opa_r;
            alu_b_r   <= opb_r;
            ready_r   <= 1'b0;
            state_r   <= S_EXEC;
          end else begin
            illegal_r <= 1'b1;
            ready_r   <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        S_EXEC: begin
          result_r <= alu_result;
          ready_r  <= 1'b0;
          state_r  <= S_WB;
        end
        S_WB: begin
          wb_valid_r <= 1'b1;
          wb_rd_r    <= rd_r;
          wb_data_r  <= result_r;
`ifdef ALU_RESULT_CHECK_EN
          chk_err_r  <= (ref_result(alu_ctl_r, alu_a_r, alu_b_r) != result_r);
`endif
          ready_r    <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
